// File: rtl/gen_pipe_skid_pkg.sv
// -----------------------------------------------------------------------------
// gen_pipe_skid_pkg
// Shared definitions for the two-entry skid buffer.
//   - skid_state_e : occupancy state encoding (EMPTY / ONE / FULL)
//   - skid_level   : maps a state to its occupancy count (0/1/2)
// -----------------------------------------------------------------------------
package gen_pipe_skid_pkg;

  // The encoding is chosen so that the state value equals the occupancy.
  // 2'b11 is unused and is treated as illegal.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b01,
    SKID_FULL  = 2'b10
  } skid_state_e;

  // Occupancy of the buffer for a given state. The illegal encoding
  // reports 0 because it is forced back to EMPTY on the next edge.
  function automatic logic [1:0] skid_level(input skid_state_e st);
    logic [1:0] lvl;
    case (st)
      SKID_EMPTY: lvl = 2'd0;
      SKID_ONE:   lvl = 2'd1;
      SKID_FULL:  lvl = 2'd2;
      default:    lvl = 2'd0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/gen_pipe_skid.sv
// -----------------------------------------------------------------------------
// gen_pipe_skid
// Two-entry skid buffer for valid/ready pipeline stages. The upstream ready
// is decoded purely from the state register, so no combinational path exists
// from out_ready to in_ready, yet one transfer per cycle is sustained.
//
// Ports
//   clk        in   1    clock, all state updates on the rising edge
//   rst        in   1    synchronous reset, active-high
//   flush      in   1    synchronous flush: drop contents, out_data <= def_val
//   def_val    in   DW   value shown on out_data after reset/flush and when empty
//   in_valid   in   1    upstream data valid
//   in_ready   out  1    buffer can accept a word (not FULL)
//   in_data    in   DW   upstream data
//   out_valid  out  1    MAIN entry holds valid data
//   out_ready  in   1    downstream accepts
//   out_data   out  DW   MAIN entry data
//   level      out  2    occupancy 0/1/2
// -----------------------------------------------------------------------------
module gen_pipe_skid
  import gen_pipe_skid_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [DW-1:0] def_val,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    level
);

  skid_state_e   state_q, state_d;
  logic [DW-1:0] main_q,  main_d;
  logic [DW-1:0] skid_q,  skid_d;

  logic          push;
  logic          pop;

  // Outputs come straight from the state/data flops. The illegal encoding
  // reads as neither valid nor full so it can never emit or block a transfer.
  assign out_valid = (state_q == SKID_ONE) || (state_q == SKID_FULL);
  assign in_ready  = (state_q != SKID_FULL);
  assign out_data  = main_q;
  assign level     = skid_level(state_q);

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Next-state and next-data selection for the MAIN and SKID entries.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      // A push completing in the flush cycle is intentionally dropped.
      state_d = SKID_EMPTY;
      main_d  = def_val;
      skid_d  = def_val;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (push) begin
            state_d = SKID_ONE;
            main_d  = in_data;
          end else begin
            state_d = SKID_EMPTY;
            main_d  = main_q;
          end
        end

        SKID_ONE: begin
          if (push && !pop) begin
            // Downstream stalled: park the new word behind MAIN.
            state_d = SKID_FULL;
            skid_d  = in_data;
          end else if (push && pop) begin
            state_d = SKID_ONE;
            main_d  = in_data;
          end else if (pop) begin
            // Draining to empty re-samples def_val for the idle value.
            state_d = SKID_EMPTY;
            main_d  = def_val;
          end else begin
            state_d = SKID_ONE;
            main_d  = main_q;
          end
        end

        SKID_FULL: begin
          // in_ready is low here, so only a pop can occur.
          if (pop) begin
            state_d = SKID_ONE;
            main_d  = skid_q;
          end else begin
            state_d = SKID_FULL;
            main_d  = main_q;
          end
        end

        default: begin
          state_d = SKID_EMPTY;
          main_d  = def_val;
          skid_d  = def_val;
        end
      endcase
    end
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SKID_EMPTY;
      main_q  <= def_val;
      skid_q  <= def_val;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_gen_pipe_skid.sv
// -----------------------------------------------------------------------------
// tb_gen_pipe_skid
// Self-checking bench for gen_pipe_skid. Directed sequences check explicit
// values; a monitor keeps a scoreboard queue of accepted words, compares each
// popped word, and checks level/in_ready/out_valid against the queue depth.
// -----------------------------------------------------------------------------
module tb_gen_pipe_skid;

  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [DW-1:0] def_val;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    level;

  int checks;
  int failures;

  logic [DW-1:0] sb[$];

  gen_pipe_skid #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .def_val   (def_val),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: check state against the model depth, then account
  // for the handshakes that will complete on the coming rising edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      check("mon_level", {30'd0, level}, sb.size());
      check("mon_in_ready", {31'd0, in_ready}, {31'd0, sb.size() != 2});
      check("mon_out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL mon_unexpected_pop: got %h expected none", out_data);
          end else begin
            check("mon_data", out_data, sb[0]);
            void'(sb.pop_front());
          end
        end
        if (in_valid && in_ready) sb.push_back(in_data);
      end
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    def_val   = 32'hDEAD_BEEF;
    in_valid  = 1'b1;          // must be ignored during reset
    in_data   = 32'h1234_5678;
    out_ready = 1'b0;

    // 1 Reset
    tick();
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_data", out_data, 32'hDEAD_BEEF);
    check("rst_level", {30'd0, level}, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);

    // 2 Streaming with out_ready high
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = i;
      tick();
      check("stream_data", out_data, i);
      check("stream_valid", {31'd0, out_valid}, 32'd1);
      check("stream_level", {30'd0, level}, 32'd1);
      check("stream_in_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain_level", {30'd0, level}, 32'd0);
    check("stream_drain_data", out_data, 32'hDEAD_BEEF);

    // 3 Backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd10;
    tick();
    in_data   = 32'd11;
    tick();
    check("bp_level_full", {30'd0, level}, 32'd2);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    in_data   = 32'd12;
    tick();
    check("bp_hold_level", {30'd0, level}, 32'd2);
    check("bp_hold_data", out_data, 32'd10);
    out_ready = 1'b1;
    tick();
    check("bp_pop1_data", out_data, 32'd11);
    check("bp_pop1_level", {30'd0, level}, 32'd1);
    tick();
    check("bp_pop2_data", out_data, 32'd12);
    check("bp_pop2_level", {30'd0, level}, 32'd1);
    in_valid  = 1'b0;
    tick();
    check("bp_empty_level", {30'd0, level}, 32'd0);

    // 4 Simultaneous push+pop in ONE, plus def_val change while non-empty
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd5;
    tick();
    def_val   = 32'h0BAD_F00D;
    in_valid  = 1'b0;
    tick();
    check("defval_ignored", out_data, 32'd5);
    in_valid  = 1'b1;
    in_data   = 32'd6;
    out_ready = 1'b1;
    tick();
    check("pushpop_data", out_data, 32'd6);
    check("pushpop_level", {30'd0, level}, 32'd1);
    in_valid  = 1'b0;
    tick();
    check("pushpop_drain", out_data, 32'h0BAD_F00D);

    // 5 Flush while FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd7;
    tick();
    in_data   = 32'd8;
    tick();
    check("fl_full", {30'd0, level}, 32'd2);
    def_val   = 32'hCAFE_0001;
    flush     = 1'b1;
    in_data   = 32'd9;
    tick();
    check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check("fl_level", {30'd0, level}, 32'd0);
    check("fl_out_data", out_data, 32'hCAFE_0001);
    check("fl_in_ready", {31'd0, in_ready}, 32'd1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("fl_stays_empty", {31'd0, out_valid}, 32'd0);
    check("fl_no_9", out_data, 32'hCAFE_0001);

    // 6 Random traffic checked by the monitor
    for (int c = 0; c < 4000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      flush     = ($urandom_range(0, 63) == 0);
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    check("final_empty", {30'd0, level}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
